// File: rtl/pulse_burst_scheduler.sv
// Round-robin scheduler that shares one pulse-train generator between N_REQ trigger sources.
// Rising request edges queue one burst per source; each burst is PULSE_LEN/GAP_LEN shaped.
module pulse_burst_scheduler #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned PULSE_LEN = 3,
   parameter int unsigned GAP_LEN   = 2,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [CNT_W-1:0] burst_len,
   output logic             pulse_out,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IDX_W  = $clog2(N_REQ);
   localparam int unsigned PH_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0] PulseLoad = PH_W'(PULSE_LEN - 1);
   localparam logic [PH_W-1:0] GapLoad   = PH_W'(GAP_LEN - 1);

   typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   req_d_q;
   logic [N_REQ-1:0]   pending_q, pending_d, pending_clr;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic               pulse_q, pulse_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [N_REQ-1:0]   rise;
   logic [IDX_W-1:0]   sel_idx;
   logic               found;
   int unsigned        idx;

   assign rise = req & ~req_d_q;

   // First pending source at or after rr_q, wrapping modulo N_REQ.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && pending_q[idx[IDX_W-1:0]]) begin
            found   = 1'b1;
            sel_idx = idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      pending_clr = '0;
      rr_d        = rr_q;
      sel_d       = sel_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      pulse_d     = 1'b0;
      grant_d     = grant_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d     = StPulse;
               sel_d       = sel_idx;
               pending_clr = N_REQ'(1) << sel_idx;
               grant_d     = N_REQ'(1) << sel_idx;
               remaining_d = (burst_len == '0) ? CNT_W'(1) : burst_len;
               phase_d     = PulseLoad;
               pulse_d     = 1'b1;
               busy_d      = 1'b1;
            end
         end
         StPulse: begin
            if (phase_q == '0) begin
               if (remaining_q > CNT_W'(1)) begin
                  state_d     = StGap;
                  remaining_d = remaining_q - 1'b1;
                  phase_d     = GapLoad;
               end else begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end else begin
               phase_d = phase_q - 1'b1;
               pulse_d = 1'b1;
            end
         end
         StGap: begin
            if (phase_q == '0) begin
               state_d = StPulse;
               phase_d = PulseLoad;
               pulse_d = 1'b1;
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            grant_d = '0;
            busy_d  = 1'b0;
            rr_d    = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // A fresh edge on the granted source in the grant cycle must survive the clear.
      pending_d = (pending_q & ~pending_clr) | rise;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         req_d_q     <= '0;
         pending_q   <= '0;
         rr_q        <= '0;
         sel_q       <= '0;
         remaining_q <= '0;
         phase_q     <= '0;
         pulse_q     <= 1'b0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_d_q     <= req;
         pending_q   <= pending_d;
         rr_q        <= rr_d;
         sel_q       <= sel_d;
         remaining_q <= remaining_d;
         phase_q     <= phase_d;
         pulse_q     <= pulse_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pulse_out = pulse_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a burst-level
// reference model that expands each granted burst into its expected output waveform.
module tb_pulse_burst_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned PL = 3;
   localparam int unsigned GL = 2;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [CW-1:0] burst_len;
   logic          pulse_out;
   logic [N-1:0]  grant;
   logic          busy;
   logic          done;

   pulse_burst_scheduler #(
      .N_REQ     (N),
      .PULSE_LEN (PL),
      .GAP_LEN   (GL),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .burst_len (burst_len),
      .pulse_out (pulse_out),
      .grant     (grant),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending set per source, round-robin pointer, and a queue of
   // expected per-cycle outputs for the burst in flight (ending with one idle cycle).
   typedef struct packed {
      logic         p;
      logic [N-1:0] g;
      logic         b;
      logic         d;
   } out_t;

   out_t         wave[$];
   out_t         m_out;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_prev;
   int unsigned  m_rr;

   task automatic model_reset();
      m_pend = '0;
      m_prev = '0;
      m_rr   = 0;
      wave.delete();
      m_out  = '0;
   endtask

   task automatic push_burst(input int unsigned sel, input int unsigned bl);
      int unsigned  nb;
      logic [N-1:0] g;
      out_t         e;
      nb     = (bl == 0) ? 1 : bl;
      g      = '0;
      g[sel] = 1'b1;
      for (int unsigned k = 0; k < nb; k++) begin
         e = '{p: 1'b1, g: g, b: 1'b1, d: 1'b0};
         repeat (PL) wave.push_back(e);
         if (k + 1 < nb) begin
            e = '{p: 1'b0, g: g, b: 1'b1, d: 1'b0};
            repeat (GL) wave.push_back(e);
         end
      end
      e = '{p: 1'b0, g: g, b: 1'b1, d: 1'b1};
      wave.push_back(e);
      e = '0;
      wave.push_back(e);
   endtask

   task automatic model_step();
      logic [N-1:0] rise;
      int unsigned  sel;
      rise   = req & ~m_prev;
      m_prev = req;
      if (wave.size() != 0) begin
         m_out = wave.pop_front();
      end else if (m_pend != '0) begin
         sel = m_rr;
         while (!m_pend[sel]) sel = (sel + 1) % N;
         m_pend[sel] = 1'b0;
         m_rr        = (sel + 1) % N;
         push_burst(sel, 32'(burst_len));
         m_out = wave.pop_front();
      end else begin
         m_out = '0;
      end
      m_pend = m_pend | rise;
   endtask

   task automatic compare_outputs(input string pfx);
      check_eq({pfx, "_pulse_out"}, 32'(pulse_out), 32'(m_out.p));
      check_eq({pfx, "_grant"},     32'(grant),     32'(m_out.g));
      check_eq({pfx, "_busy"},      32'(busy),      32'(m_out.b));
      check_eq({pfx, "_done"},      32'(done),      32'(m_out.d));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      compare_outputs("cyc");
   endtask

   // Asynchronous reset applied between edges; outputs must clear without a clock.
   task automatic async_reset(input int hold);
      rst = 1'b1;
      #1;
      model_reset();
      compare_outputs("async_rst");
      repeat (hold) tick();
      rst = 1'b0;
   endtask

   logic [N-1:0] order[$];
   int           n_busy, n_pulse, n_done;

   task automatic run_collect(input int n);
      logic [N-1:0] prev_g;
      order.delete();
      n_busy  = 0;
      n_pulse = 0;
      n_done  = 0;
      prev_g  = grant;
      repeat (n) begin
         tick();
         if (grant != '0 && grant != prev_g) order.push_back(grant);
         prev_g = grant;
         if (busy) n_busy++;
         if (pulse_out) n_pulse++;
         if (done) n_done++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      burst_len = '0;
      model_reset();
      #2;
      compare_outputs("reset");
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // Single edge on req[1], two pulses.
      burst_len = 4'd2;
      req       = 4'b0010;
      run_collect(14);
      check_eq("s1_busy_cycles", 32'(n_busy), 32'd9);
      check_eq("s1_pulse_cycles", 32'(n_pulse), 32'd6);
      check_eq("s1_grant", 32'(order.size() > 0 ? order[0] : '0), 32'h2);
      req = '0;
      tick();

      // Simultaneous rise on all sources from a fresh reset.
      async_reset(2);
      burst_len = 4'd1;
      tick();
      req = 4'b1111;
      run_collect(24);
      check_eq("s2_order_len", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         check_eq($sformatf("s2_order%0d", i), 32'(order[i]), 32'(1 << i));
      req = '0;
      tick();

      // Fairness: serve req[2], then req[0] and req[3] together.
      req = 4'b0100;
      run_collect(8);
      req = '0;
      tick();
      req = 4'b1001;
      run_collect(14);
      check_eq("s3_order_len", 32'(order.size()), 32'd2);
      if (order.size() == 2) begin
         check_eq("s3_first", 32'(order[0]), 32'h8);
         check_eq("s3_second", 32'(order[1]), 32'h1);
      end
      req = '0;
      tick();

      // burst_len of zero gives one pulse.
      burst_len = 4'd0;
      req       = 4'b0001;
      run_collect(8);
      check_eq("s4_pulses", 32'(n_pulse), 32'd3);
      check_eq("s4_done", 32'(n_done), 32'd1);
      req = '0;
      tick();

      // Re-trigger during own burst, then hold high.
      burst_len = 4'd3;
      req       = 4'b0100;
      n_done    = 0;
      repeat (4) tick();
      req = 4'b0000; tick();
      req = 4'b0100; tick();
      req = 4'b0000; tick();
      req = 4'b0100;
      run_collect(80);
      check_eq("s5_extra_bursts", 32'(n_done), 32'd2);
      req = '0;
      tick();

      // Reset in the 2nd pulse of a 4-pulse burst with req[1] pending.
      async_reset(1);
      burst_len = 4'd4;
      req       = 4'b0001;
      tick();
      req = 4'b0011;
      tick();
      req = 4'b0000;
      repeat (6) tick();
      check_eq("s6_pre_rst_pulse", 32'(pulse_out), 32'd1);
      check_eq("s6_pre_rst_grant", 32'(grant), 32'h1);
      async_reset(2);
      run_collect(20);
      check_eq("s6_idle_after_rst", 32'(n_busy), 32'd0);
      req = 4'b0010;
      run_collect(25);
      check_eq("s6_new_edge_grant", 32'(order.size() > 0 ? order[0] : '0), 32'h2);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) req[$urandom_range(N - 1)] ^= 1'b1;
         if ($urandom_range(15) == 0) burst_len = CW'($urandom_range(15));
         if ($urandom_range(699) == 0) async_reset($urandom_range(1, 2));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pulse_burst_scheduler.md
Name: pulse_burst_scheduler

Overview:
- Shares one pulse-train generator between N_REQ trigger sources, e.g. push-button triggers after their one-pulse/three-pulse conditioning.
- Captures rising edges on each request line and queues one pending bit per source.
- Grants sources round-robin and emits a burst of fixed-width active-high pulses for the granted source.
- Sits between the trigger-conditioning stage and the shared consumer (counter or display driver). The consumer uses grant to steer pulse_out.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- PULSE_LEN, 3, clock cycles pulse_out stays high per pulse (>=1)
- GAP_LEN, 2, clock cycles pulse_out stays low between pulses of one burst (>=1)
- CNT_W, 4, width of burst_len and the internal pulse counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  level trigger per source; a 0->1 transition queues one burst
- burst_len  input  CNT_W  pulses per burst; sampled on the grant edge; value 0 treated as 1
- pulse_out  output  1  shared pulse train, registered
- grant  output  N_REQ  one-hot owner of the current burst, registered; all zero when idle
- busy  output  1  high in PULSE, GAP and DONE states
- done  output  1  one-cycle strobe marking the end of a burst

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pending=0; req_d=0; rr_ptr=0; counters=0.
  - pulse_out=0, grant=0, busy=0, done=0.
  - Applies immediately, including mid-burst. After release, no burst resumes.
- Edge capture:
  - req_d registers req every cycle.
  - pending[i] is set on an edge where req[i]=1 and req_d[i]=0.
  - A level held high queues exactly one burst.
  - An edge on an already-pending source is absorbed; there is no count beyond 1.
- Arbitration:
  - In IDLE with pending!=0, select the first set bit searching from index rr_ptr upward, wrapping modulo N_REQ.
  - After each burst completes, rr_ptr = selected index + 1, with wrap to 0.
- State machine: IDLE, PULSE, GAP, DONE.
  - IDLE -> PULSE at the edge after pending becomes nonzero.
    - Load grant = onehot(sel), clear pending[sel].
    - Load remaining = (burst_len==0 ? 1 : burst_len).
    - Load phase counter = PULSE_LEN-1. Drive pulse_out=1, busy=1.
    - If a new edge on req[sel] occurs in this same cycle, set wins over clear and pending[sel] stays 1.
  - PULSE: pulse_out=1 for exactly PULSE_LEN cycles. At the end of the phase:
    - if remaining>1: go to GAP, decrement remaining, phase = GAP_LEN-1;
    - else: go to DONE.
  - GAP: pulse_out=0 for exactly GAP_LEN cycles, then PULSE with phase = PULSE_LEN-1.
  - DONE: one cycle with done=1, pulse_out=0, grant still held, busy=1. Next edge goes to IDLE: grant=0, busy=0, rr_ptr updated.
- Timing:
  - Minimum idle gap between bursts is 1 cycle: DONE -> IDLE -> PULSE.
  - A burst of B pulses occupies B*PULSE_LEN + (B-1)*GAP_LEN + 1 cycles from first pulse_out high to done.
- Other rules:
  - burst_len and req changes during a burst do not alter the burst in progress.
  - Requests arriving during a burst only set pending bits.
  - All outputs come straight from flops; there are no combinational paths from input to output.

Test Plan:
- Reset then single edge on req[1] with burst_len=2, defaults:
  - grant=0010 from the cycle after the edge;
  - pulse_out pattern 1,1,1,0,0,1,1,1, then done=1 for 1 cycle;
  - grant=0 one cycle later. Total busy 9 cycles.
- req=1111 rising simultaneously, burst_len=1:
  - grants served in order 0001, 0010, 0100, 1000, each a 3-cycle pulse plus DONE;
  - one IDLE cycle between bursts.
- Round-robin fairness:
  - after serving req[2], raise req[0] and req[3] together;
  - req[3] is granted first (rr_ptr=3), then req[0].
- burst_len=0 with an edge on req[0] -> exactly one 3-cycle pulse, then done.
- Re-trigger and hold: while req[2] is busy with burst_len=3, toggle req[2] 0->1 twice.
  - Exactly one further burst for req[2] follows.
  - Holding req[2] high for 50 cycles produces no further bursts.
- Reset mid-operation: assert rst during the 2nd pulse of a 4-pulse burst with req[1] also pending.
  - All outputs go to 0 immediately.
  - After release with req held steady, no burst occurs until a new rising edge.
